axis_rational_width_converter: RTL and testbench

Parametrised successor to the integer-ratio AXI-stream width converter. It repacks a stream of `IN_SAMPLES` samples per input word into `OUT_SAMPLES` samples per output word for any ratio; the two counts need not divide each other. Packets are delimited by `last`. A packet's final output word is zero-padded, and carries an explicit count of its valid samples, so downstream logic never discards garbage subwords. It sits between ADC/DAC sample streams and DMA/processing blocks of a different lane count.

---
 rtl/axis_rational_width_converter_if.sv | 13 +
 rtl/axis_rational_width_converter.sv | 107 ++++++++++
 tb/tb_axis_rational_width_converter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rational_width_converter_if.sv
// AXI-stream bundle carrying data, valid, ready and last.
// Ports: master drives data/valid/last; slave drives ready.
interface Axis_If #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, valid, last, input ready);
    modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/axis_rational_width_converter.sv
// Repacks IN_SAMPLES-wide words into OUT_SAMPLES-wide words.
// Ports: clk, reset (async, active-low), data_in (slave),
// data_out (master), out_valid_samples (count in output word).
module axis_rational_width_converter #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int IN_SAMPLES   = 2,
    parameter int OUT_SAMPLES  = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    Axis_If.slave                              data_in,
    Axis_If.master                             data_out,
    output logic [$clog2(OUT_SAMPLES+1)-1:0]   out_valid_samples
);
    localparam int CAP = 2 * (IN_SAMPLES + OUT_SAMPLES);
    localparam int CW  = $clog2(CAP + 1);
    localparam int VW  = $clog2(OUT_SAMPLES + 1);
    localparam int SW  = SAMPLE_WIDTH;

    localparam logic [CW-1:0] IN_C  = CW'(IN_SAMPLES);
    localparam logic [CW-1:0] OUT_C = CW'(OUT_SAMPLES);
    localparam logic [CW-1:0] CAP_C = CW'(CAP);

    typedef enum logic {FILL, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] base;
    logic [SW-1:0] mem_q [CAP];
    logic [SW-1:0] mem_d [CAP];
    logic          vld;
    logic          tail;
    logic          push;
    logic          pop;

    // tail: the word on offer closes the packet
    always_comb begin
        tail = (state_q == FLUSH) && (count_q <= OUT_C);
        vld  = 1'b0;
        unique case (state_q)
            FILL:  vld = (count_q >= OUT_C);
            FLUSH: vld = (count_q != '0);
            default: vld = 1'b0;
        endcase
    end

    // ready is gated by reset so it reads 0 while held in reset
    always_comb begin
        data_in.ready = reset && (state_q == FILL)
                        && (count_q <= CAP_C - IN_C);
        data_out.valid = vld;
        data_out.last  = vld && tail;
        out_valid_samples = '0;
        if (vld)
            out_valid_samples = tail ? VW'(count_q)
                                     : VW'(OUT_SAMPLES);
        data_out.data = '0;
        for (int j = 0; j < OUT_SAMPLES; j++) begin
            if (vld && (!tail || CW'(j) < count_q))
                data_out.data[j*SW +: SW] = mem_q[j];
        end
    end

    // slot 0 always holds the oldest sample; a pop shifts
    // the buffer down, a push lands just above the survivors
    always_comb begin
        push    = data_in.valid && data_in.ready;
        pop     = vld && data_out.ready;
        state_d = state_q;
        base    = count_q;
        if (pop)
            base = tail ? '0 : count_q - OUT_C;
        for (int i = 0; i < CAP; i++) begin
            mem_d[i] = pop ? mem_q[(i + OUT_SAMPLES) % CAP]
                           : mem_q[i];
            if (push && CW'(i) >= base
                     && CW'(i) < base + IN_C)
                mem_d[i] = data_in.data[
                    (i - int'(base)) * SW +: SW];
        end
        count_d = base + (push ? IN_C : '0);
        unique case (state_q)
            FILL:
                if (push && data_in.last)
                    state_d = FLUSH;
            FLUSH:
                if (pop && tail)
                    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // contents past count are don't-care, so no reset needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_axis_rational_width_converter.sv
// Scoreboard bench for axis_rational_width_converter.
// Directed tests on IN=2/OUT=3 plus a randomised ratio sweep.
module tb_axis_rational_width_converter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sreset;
    int   checks = 0;
    int   passes = 0;
    int   sweep_done = 0;

    task automatic chk(input string name, input bit ok,
                       input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    Axis_If #(.DWIDTH(32)) din ();
    Axis_If #(.DWIDTH(48)) dout ();
    logic [1:0] ovs;

    axis_rational_width_converter #(
        .SAMPLE_WIDTH(16),
        .IN_SAMPLES(2),
        .OUT_SAMPLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_in(din),
        .data_out(dout),
        .out_valid_samples(ovs)
    );

    typedef struct packed {
        logic [47:0] d;
        logic        l;
        logic [1:0]  n;
    } exp_t;

    exp_t q[$];

    function automatic logic [31:0] w2(input int a, input int b);
        logic [15:0] x, y;
        x = 16'(a);
        y = 16'(b);
        return {y, x};
    endfunction

    function automatic exp_t e3(input int a, input int b,
                                input int c, input logic l,
                                input logic [1:0] n);
        exp_t e;
        e.d = {16'(c), 16'(b), 16'(a)};
        e.l = l;
        e.n = n;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        chk("count_bound", dut.count_q <= 4'd10,
            longint'(dut.count_q), 10);
        if (!dout.valid) begin
            chk("idle_zero",
                dout.data == '0 && ovs == '0 && !dout.last,
                longint'(dout.data), 0);
        end else if (dout.ready) begin
            if (q.size() == 0) begin
                chk("spurious_word", 1'b0,
                    longint'(dout.data), 0);
            end else begin
                e = q.pop_front();
                chk("word_data", dout.data === e.d,
                    longint'(dout.data), longint'(e.d));
                chk("word_last", dout.last === e.l,
                    longint'(dout.last), longint'(e.l));
                chk("word_nvalid", ovs === e.n,
                    longint'(ovs), longint'(e.n));
            end
        end
    end

    // call at posedge+1; returns at posedge+1 after handshake
    task automatic put(input logic [31:0] d, input logic l,
                       output int waits);
        waits = 0;
        din.data  = d;
        din.valid = 1'b1;
        din.last  = l;
        @(negedge clk);
        while (!din.ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!din.ready)
            chk("put_timeout", 1'b0, waits, 0);
        @(posedge clk);
        #1;
        din.valid = 1'b0;
        din.last  = 1'b0;
        din.data  = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size() == 0, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   w;
        int   k;
        int   n;
        exp_t ex;
        reset      = 1'b0;
        sreset     = 1'b0;
        din.valid  = 1'b0;
        din.last   = 1'b0;
        din.data   = '0;
        dout.ready = 1'b0;
        #12;
        chk("rst_ready", din.ready == 1'b0, din.ready, 0);
        chk("rst_valid", dout.valid == 1'b0, dout.valid, 0);
        chk("rst_last", dout.last == 1'b0, dout.last, 0);
        chk("rst_data", dout.data == '0, longint'(dout.data), 0);
        chk("rst_nvalid", ovs == '0, ovs, 0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        sreset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", din.ready == 1'b1, din.ready, 1);
        @(posedge clk);
        #1;

        // exact multiple of OUT
        dout.ready = 1'b1;
        q.push_back(e3(0, 1, 2, 1'b0, 2'd3));
        q.push_back(e3(3, 4, 5, 1'b1, 2'd3));
        put(w2(0, 1), 1'b0, w);
        put(w2(2, 3), 1'b0, w);
        @(negedge clk);
        chk("first_latency", dout.valid == 1'b1, dout.valid, 1);
        @(posedge clk);
        #1;
        put(w2(4, 5), 1'b1, w);
        @(negedge clk);
        chk("flush_latency", dout.last == 1'b1, dout.last, 1);
        @(posedge clk);
        #1;
        drain();

        // zero-padded tail
        q.push_back(e3(0, 1, 2, 1'b0, 2'd3));
        q.push_back(e3(3, 0, 0, 1'b1, 2'd1));
        put(w2(0, 1), 1'b0, w);
        put(w2(2, 3), 1'b1, w);
        drain();

        // full buffer under backpressure
        dout.ready = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            din.data  = w2(100 + 2*k, 101 + 2*k);
            din.valid = 1'b1;
            din.last  = 1'b0;
            @(negedge clk);
            if (din.ready) k++;
            @(posedge clk);
            #1;
        end
        din.valid = 1'b0;
        chk("full_accepts", k == 5, k, 5);
        @(negedge clk);
        chk("full_ready_low", din.ready == 1'b0, din.ready, 0);
        chk("full_count", dut.count_q == 4'd10,
            longint'(dut.count_q), 10);
        q.push_back(e3(100, 101, 102, 1'b0, 2'd3));
        q.push_back(e3(103, 104, 105, 1'b0, 2'd3));
        q.push_back(e3(106, 107, 108, 1'b0, 2'd3));
        q.push_back(e3(109, 110, 111, 1'b1, 2'd3));
        @(posedge clk);
        #1;
        dout.ready = 1'b1;
        put(w2(110, 111), 1'b1, w);
        drain();

        // reset while flushing with count 4
        dout.ready = 1'b0;
        put(w2(1, 2), 1'b0, w);
        put(w2(3, 4), 1'b1, w);
        ex = e3(1, 2, 3, 1'b0, 2'd3);
        @(negedge clk);
        chk("bp_valid", dout.valid == 1'b1, dout.valid, 1);
        chk("bp_data0", dout.data == ex.d,
            longint'(dout.data), longint'(ex.d));
        @(negedge clk);
        chk("bp_data1", dout.data == ex.d,
            longint'(dout.data), longint'(ex.d));
        chk("bp_last", dout.last == 1'b0, dout.last, 0);
        chk("bp_nvalid", ovs == 2'd3, ovs, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", dout.valid == 1'b0, dout.valid, 0);
        chk("arst_last", dout.last == 1'b0, dout.last, 0);
        chk("arst_data", dout.data == '0, longint'(dout.data), 0);
        chk("arst_ready", din.ready == 1'b0, din.ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rerst_ready", din.ready == 1'b1, din.ready, 1);
        @(posedge clk);
        #1;
        dout.ready = 1'b1;
        q.push_back(e3(10, 11, 12, 1'b0, 2'd3));
        q.push_back(e3(13, 14, 15, 1'b1, 2'd3));
        put(w2(10, 11), 1'b0, w);
        put(w2(12, 13), 1'b0, w);
        put(w2(14, 15), 1'b1, w);
        drain();

        // back-to-back packets
        q.push_back(e3(20, 21, 22, 1'b0, 2'd3));
        q.push_back(e3(23, 0, 0, 1'b1, 2'd1));
        q.push_back(e3(30, 31, 32, 1'b0, 2'd3));
        q.push_back(e3(33, 34, 35, 1'b1, 2'd3));
        put(w2(20, 21), 1'b0, w);
        put(w2(22, 23), 1'b1, w);
        put(w2(30, 31), 1'b0, w);
        chk("b2b_wait", w == 2, w, 2);
        put(w2(32, 33), 1'b0, w);
        put(w2(34, 35), 1'b1, w);
        drain();

        n = 0;
        while (sweep_done < 6 && n < 40000) begin
            @(posedge clk);
            n++;
        end
        chk("sweep_done", sweep_done == 6, sweep_done, 6);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    localparam int NCFG = 6;
    localparam int CI [NCFG] = '{3, 1, 2, 3, 1, 4};
    localparam int CO [NCFG] = '{1, 3, 3, 2, 1, 7};

    for (genvar g = 0; g < NCFG; g++) begin : g_sw
        localparam int I  = CI[g];
        localparam int O  = CO[g];
        localparam int VW = $clog2(O + 1);

        Axis_If #(.DWIDTH(16*I)) si ();
        Axis_If #(.DWIDTH(16*O)) so ();
        logic [VW-1:0] sovs;

        axis_rational_width_converter #(
            .SAMPLE_WIDTH(16),
            .IN_SAMPLES(I),
            .OUT_SAMPLES(O)
        ) u (
            .clk(clk),
            .reset(sreset),
            .data_in(si),
            .data_out(so),
            .out_valid_samples(sovs)
        );

        logic [15:0] es[$];
        int          et[$];
        int          got = 0;
        int          pk = 0;

        initial begin
            logic [16*I-1:0] w;
            logic [15:0]     smp;
            int              nw;
            int              n;
            smp      = 16'(g * 4096 + 1);
            si.valid = 1'b0;
            si.last  = 1'b0;
            si.data  = '0;
            @(posedge sreset);
            @(posedge clk);
            #1;
            for (int p = 0; p < 3; p++) begin
                nw = $urandom_range(3, 100);
                et.push_back(nw * I);
                for (int k = 0; k < nw; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    for (int s = 0; s < I; s++) begin
                        w[s*16 +: 16] = smp;
                        es.push_back(smp);
                        smp++;
                    end
                    si.data  = w;
                    si.valid = 1'b1;
                    si.last  = (k == nw - 1);
                    n = 0;
                    @(negedge clk);
                    while (!si.ready && n < 500) begin
                        n++;
                        @(negedge clk);
                    end
                    @(posedge clk);
                    #1;
                    si.valid = 1'b0;
                    si.last  = 1'b0;
                end
            end
        end

        initial begin
            so.ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                so.ready = ($urandom_range(0, 3) != 0);
            end
        end

        always @(negedge clk) begin
            logic [15:0] ev;
            int          t;
            chk("sw_count_bound",
                int'(u.count_q) <= 2 * (I + O),
                longint'(u.count_q), 2 * (I + O));
            if (so.valid && so.ready) begin
                for (int s = 0; s < O; s++) begin
                    if (s < int'(sovs)) begin
                        if (es.size() == 0) begin
                            chk("sw_extra_sample", 1'b0,
                                longint'(so.data[s*16 +: 16]), 0);
                        end else begin
                            ev = es.pop_front();
                            chk("sw_sample",
                                so.data[s*16 +: 16] === ev,
                                longint'(so.data[s*16 +: 16]),
                                longint'(ev));
                        end
                    end else begin
                        chk("sw_pad", so.data[s*16 +: 16] == '0,
                            longint'(so.data[s*16 +: 16]), 0);
                    end
                end
                got += int'(sovs);
                if (so.last) begin
                    if (et.size() == 0) begin
                        chk("sw_extra_last", 1'b0, got, 0);
                    end else begin
                        t = et.pop_front();
                        chk("sw_pkt_total", got == t, got, t);
                        chk("sw_last_nvalid",
                            int'(sovs) == ((t - 1) % O) + 1,
                            longint'(sovs), ((t - 1) % O) + 1);
                    end
                    got = 0;
                    pk++;
                    if (pk == 3) sweep_done++;
                end else begin
                    chk("sw_full_nvalid", int'(sovs) == O,
                        longint'(sovs), O);
                end
            end
        end
    end
endmodule
